// File: rtl/div_frac_mc.sv
// div_frac_mc - multi-channel fractional rate generator.
//
// Each channel accumulates its divisor S every enabled cycle and emits a
// one-cycle tick whenever the accumulator reaches the dividend D, giving an
// average rate of S/D ticks per clock. Alongside each tick the channel reports
// how many cycles the period it just closed lasted.
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   rst           synchronous, active-low reset
//   cfg_valid     config write request
//   cfg_ready     config port can accept (drops for one cycle after a write)
//   cfg_ch        target channel of the config write
//   cfg_dividend  D for the target channel
//   cfg_divisor   S for the target channel
//   cfg_mode      0 = fractional (carry remainder), 1 = integer (drop remainder)
//   cfg_en        channel enable
//   sync          restart the phase of every enabled channel
//   tick          one-cycle pulse per channel
//   period        channel i at [i*DATA_W +: DATA_W], length of last period
//   locked        channel has ticked since its last config write or reset
module div_frac_mc #(
  parameter int DATA_W = 32,
  parameter int NCH    = 4,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [DATA_W-1:0]     cfg_dividend,
  input  logic [DATA_W-1:0]     cfg_divisor,
  input  logic                  cfg_mode,
  input  logic                  cfg_en,
  input  logic                  sync,
  output logic [NCH-1:0]        tick,
  output logic [NCH*DATA_W-1:0] period,
  output logic [NCH-1:0]        locked
);

  logic cfg_accept;

  assign cfg_accept = cfg_valid && cfg_ready;

  // The config port is closed for the cycle after every accepted write, which
  // limits back-to-back writes to one every two cycles. It also stays closed
  // on the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= !cfg_accept;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      logic [DATA_W-1:0] d_q;
      logic [DATA_W-1:0] s_q;
      logic              mode_q;
      logic              en_q;
      logic [DATA_W:0]   acc_q;
      logic [DATA_W-1:0] cnt_q;
      logic              tick_q;
      logic [DATA_W-1:0] period_q;
      logic              locked_q;

      logic              hit;
      logic [DATA_W:0]   sum;
      logic [DATA_W:0]   acc_n;
      logic [DATA_W-1:0] cnt_n;
      logic              tick_n;
      logic [DATA_W-1:0] period_n;
      logic              locked_n;

      // A write addressed beyond the last channel matches no channel and is
      // therefore silently discarded.
      assign hit = cfg_accept && (cfg_ch == CH_W'(i));

      // acc always stays below D, so one extra bit is enough for acc + S.
      assign sum = acc_q + {1'b0, s_q};

      // Next-state decision with precedence config write > sync > counting.
      // A disabled channel holds everything and never ticks.
      always_comb begin
        acc_n    = acc_q;
        cnt_n    = cnt_q;
        tick_n   = 1'b0;
        period_n = period_q;
        locked_n = locked_q;
        if (hit) begin
          acc_n    = '0;
          cnt_n    = DATA_W'(1);
          locked_n = 1'b0;
        end else if (en_q) begin
          if (sync) begin
            acc_n = '0;
            cnt_n = DATA_W'(1);
          end else if (s_q >= d_q) begin
            // Rate of one or more per cycle (including D = 0): tick every cycle.
            tick_n   = 1'b1;
            period_n = DATA_W'(1);
            acc_n    = '0;
            cnt_n    = DATA_W'(1);
            locked_n = 1'b1;
          end else if (sum >= {1'b0, d_q}) begin
            tick_n   = 1'b1;
            period_n = cnt_q;
            cnt_n    = DATA_W'(1);
            acc_n    = mode_q ? '0 : (sum - {1'b0, d_q});
            locked_n = 1'b1;
          end else begin
            acc_n = sum;
            cnt_n = (&cnt_q) ? cnt_q : (cnt_q + DATA_W'(1));
          end
        end
      end

      // Channel registers. Configuration fields only change on an accepted
      // write to this channel; period survives a config write.
      always_ff @(posedge clk) begin
        if (!rst) begin
          d_q      <= '0;
          s_q      <= '0;
          mode_q   <= 1'b0;
          en_q     <= 1'b0;
          acc_q    <= '0;
          cnt_q    <= DATA_W'(1);
          tick_q   <= 1'b0;
          period_q <= '0;
          locked_q <= 1'b0;
        end else begin
          if (hit) begin
            d_q    <= cfg_dividend;
            s_q    <= cfg_divisor;
            mode_q <= cfg_mode;
            en_q   <= cfg_en;
          end
          acc_q    <= acc_n;
          cnt_q    <= cnt_n;
          tick_q   <= tick_n;
          period_q <= period_n;
          locked_q <= locked_n;
        end
      end

      assign tick[i]                     = tick_q;
      assign period[i*DATA_W +: DATA_W]  = period_q;
      assign locked[i]                   = locked_q;
    end
  endgenerate

endmodule

// File: tb/tb_div_frac_mc.sv
// tb_div_frac_mc - self-checking bench for div_frac_mc.
//
// A cycle-level behavioural model of every channel runs beside the DUT and a
// compare process checks tick, period, locked and cfg_ready on every falling
// edge. Directed scenarios add hand-computed literal expectations, followed by
// a randomized phase of config writes, sync pulses and resets.
module tb_div_frac_mc;

  localparam int DATA_W = 32;
  localparam int NCH    = 4;
  localparam int CH_W   = 2;
  localparam longint CNT_MAX = (64'd1 << DATA_W) - 1;

  logic                  clk;
  logic                  rst;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CH_W-1:0]       cfg_ch;
  logic [DATA_W-1:0]     cfg_dividend;
  logic [DATA_W-1:0]     cfg_divisor;
  logic                  cfg_mode;
  logic                  cfg_en;
  logic                  sync;
  logic [NCH-1:0]        tick;
  logic [NCH*DATA_W-1:0] period;
  logic [NCH-1:0]        locked;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  // Behavioural model state
  longint m_d [NCH];
  longint m_s [NCH];
  bit     m_mode [NCH];
  bit     m_en [NCH];
  longint m_acc [NCH];
  longint m_cnt [NCH];
  bit     m_tick [NCH];
  longint m_period [NCH];
  bit     m_locked [NCH];
  bit     m_ready;
  bit     m_accept;
  longint m_sum;

  div_frac_mc #(.DATA_W(DATA_W), .NCH(NCH), .CH_W(CH_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_dividend (cfg_dividend),
    .cfg_divisor  (cfg_divisor),
    .cfg_mode     (cfg_mode),
    .cfg_en       (cfg_en),
    .sync         (sync),
    .tick         (tick),
    .period       (period),
    .locked       (locked)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: on each rising edge, apply the channel rules to the
  // inputs the DUT sees at that same edge.
  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_d[c] = 0; m_s[c] = 0; m_mode[c] = 0; m_en[c] = 0; m_acc[c] = 0;
      m_cnt[c] = 1; m_tick[c] = 0; m_period[c] = 0; m_locked[c] = 0;
    end
    m_ready = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        for (int c = 0; c < NCH; c++) begin
          m_d[c] = 0; m_s[c] = 0; m_mode[c] = 0; m_en[c] = 0; m_acc[c] = 0;
          m_cnt[c] = 1; m_tick[c] = 0; m_period[c] = 0; m_locked[c] = 0;
        end
        m_ready = 0;
      end else begin
        m_accept = cfg_valid && m_ready;
        for (int c = 0; c < NCH; c++) begin
          m_tick[c] = 0;
          if (m_accept && (int'(cfg_ch) == c)) begin
            m_d[c] = longint'(cfg_dividend);
            m_s[c] = longint'(cfg_divisor);
            m_mode[c] = cfg_mode;
            m_en[c] = cfg_en;
            m_acc[c] = 0;
            m_cnt[c] = 1;
            m_locked[c] = 0;
          end else if (m_en[c]) begin
            if (sync) begin
              m_acc[c] = 0;
              m_cnt[c] = 1;
            end else if (m_s[c] >= m_d[c]) begin
              m_tick[c] = 1; m_period[c] = 1; m_acc[c] = 0; m_cnt[c] = 1; m_locked[c] = 1;
            end else begin
              m_sum = m_acc[c] + m_s[c];
              if (m_sum >= m_d[c]) begin
                m_tick[c] = 1;
                m_period[c] = m_cnt[c];
                m_cnt[c] = 1;
                m_acc[c] = m_mode[c] ? 0 : m_sum - m_d[c];
                m_locked[c] = 1;
              end else begin
                m_acc[c] = m_sum;
                if (m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
              end
            end
          end
        end
        m_ready = !m_accept;
      end
    end
  end

  // Compare process: registered outputs are stable at the falling edge.
  initial begin
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_locked;
    forever begin
      @(negedge clk);
      if (check_en) begin
        for (int c = 0; c < NCH; c++) begin
          exp_tick[c]   = m_tick[c];
          exp_locked[c] = m_locked[c];
          checkOutput($sformatf("model_period%0d", c), 64'(period[c*DATA_W +: DATA_W]), 64'(m_period[c]));
        end
        checkOutput("model_tick", 64'(tick), 64'(exp_tick));
        checkOutput("model_locked", 64'(locked), 64'(exp_locked));
        checkOutput("model_cfg_ready", 64'(cfg_ready), 64'(m_ready));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one config write, returning on the falling edge just after the
  // accepting rising edge.
  task automatic applyStimulus(input int ch, input longint d, input longint s,
                               input bit mode, input bit en, input bit with_sync);
    int n;
    n = 0;
    while (!cfg_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) checkOutput("cfg_ready_timeout", 64'(cfg_ready), 64'd1);
    cfg_valid    = 1'b1;
    cfg_ch       = ch[CH_W-1:0];
    cfg_dividend = d[DATA_W-1:0];
    cfg_divisor  = s[DATA_W-1:0];
    cfg_mode     = mode;
    cfg_en       = en;
    sync         = with_sync;
    @(negedge clk);
    cfg_valid = 1'b0;
    sync      = 1'b0;
  endtask

  // Wait (bounded) for the next tick on a channel and return its period.
  task automatic wait_tick(input int ch, output longint per);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick[ch] && n < 64);
    if (!tick[ch]) checkOutput($sformatf("tick%0d_timeout", ch), 64'(tick[ch]), 64'd1);
    per = longint'(period[ch*DATA_W +: DATA_W]);
  endtask

  initial begin
    longint p;
    int r;
    int ch;
    longint d;
    longint s;

    rst = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_dividend = '0;
    cfg_divisor = '0; cfg_mode = 1'b0; cfg_en = 1'b0; sync = 1'b0;
    cycles(3);
    check_en = 1;
    checkOutput("reset_cfg_ready", 64'(cfg_ready), 64'd0);
    checkOutput("reset_tick", 64'(tick), 64'd0);
    checkOutput("reset_locked", 64'(locked), 64'd0);
    checkOutput("reset_period0", 64'(period[DATA_W-1:0]), 64'd0);
    rst = 1'b1;
    cycles(1);
    checkOutput("ready_after_reset", 64'(cfg_ready), 64'd1);

    // ch0 D=4 S=1: first tick on the 4th edge after the accepting edge
    applyStimulus(0, 4, 1, 0, 1, 0);
    checkOutput("ready_low_after_write", 64'(cfg_ready), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("ready_back_high", 64'(cfg_ready), 64'd1);
      if (k < 4) begin
        checkOutput($sformatf("ch0_notick_%0d", k), 64'(tick[0]), 64'd0);
        checkOutput($sformatf("ch0_unlocked_%0d", k), 64'(locked[0]), 64'd0);
      end
    end
    checkOutput("ch0_first_tick", 64'(tick[0]), 64'd1);
    checkOutput("ch0_period", 64'(period[DATA_W-1:0]), 64'd4);
    checkOutput("ch0_locked", 64'(locked[0]), 64'd1);
    wait_tick(0, p);
    checkOutput("ch0_period_again", 64'(p), 64'd4);

    // ch1 D=4 S=3 fractional: periods 2,1,1
    applyStimulus(1, 4, 3, 0, 1, 0);
    wait_tick(1, p); checkOutput("ch1_p_a", 64'(p), 64'd2);
    wait_tick(1, p); checkOutput("ch1_p_b", 64'(p), 64'd1);
    wait_tick(1, p); checkOutput("ch1_p_c", 64'(p), 64'd1);
    wait_tick(1, p); checkOutput("ch1_p_d", 64'(p), 64'd2);

    // ch2 D=8 S=3 fractional: 3,3,2; integer: 3 constant
    applyStimulus(2, 8, 3, 0, 1, 0);
    wait_tick(2, p); checkOutput("ch2_frac_a", 64'(p), 64'd3);
    wait_tick(2, p); checkOutput("ch2_frac_b", 64'(p), 64'd3);
    wait_tick(2, p); checkOutput("ch2_frac_c", 64'(p), 64'd2);
    applyStimulus(2, 8, 3, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      wait_tick(2, p);
      checkOutput($sformatf("ch2_int_%0d", k), 64'(p), 64'd3);
    end

    // Degenerate rates
    applyStimulus(1, 0, 0, 0, 1, 0);
    wait_tick(1, p); checkOutput("d0_period", 64'(p), 64'd1);
    @(negedge clk); checkOutput("d0_every_cycle", 64'(tick[1]), 64'd1);
    applyStimulus(1, 3, 5, 0, 1, 0);
    wait_tick(1, p); checkOutput("s_gt_d_period", 64'(p), 64'd1);
    applyStimulus(1, 7, 0, 0, 1, 0);
    cycles(30);
    checkOutput("s0_no_tick", 64'(tick[1]), 64'd0);
    checkOutput("s0_not_locked", 64'(locked[1]), 64'd0);

    // Sync alignment; ch2 disabled keeps its period of 3
    applyStimulus(2, 8, 3, 1, 0, 0);
    applyStimulus(0, 10, 1, 0, 1, 0);
    cycles(3);
    applyStimulus(3, 10, 1, 0, 1, 0);
    cycles(4);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k < 10) checkOutput($sformatf("sync_quiet_%0d", k), 64'({tick[3], tick[0]}), 64'd0);
    end
    checkOutput("sync_aligned", 64'({tick[3], tick[0]}), 64'd3);
    checkOutput("disabled_period_held", 64'(period[2*DATA_W +: DATA_W]), 64'd3);

    // Config and sync to the same channel in one cycle: config wins
    applyStimulus(1, 6, 1, 0, 1, 1);
    wait_tick(1, p); checkOutput("cfg_over_sync", 64'(p), 64'd6);

    // Disable mid-period: no ticks while disabled
    applyStimulus(0, 10, 1, 0, 0, 0);
    cycles(25);
    checkOutput("disabled_no_tick", 64'(tick[0]), 64'd0);

    // Reset mid-operation
    applyStimulus(0, 2, 1, 0, 1, 0);
    cycles(5);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_tick", 64'(tick), 64'd0);
    checkOutput("midreset_locked", 64'(locked), 64'd0);
    checkOutput("midreset_period", 64'(period), 64'd0);
    checkOutput("midreset_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b1;
    cycles(20);
    checkOutput("idle_after_reset", 64'(tick), 64'd0);

    // Randomized phase, checked by the compare process
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else if (r < 120 && cfg_ready) begin
        ch = int'($urandom_range(0, NCH-1));
        if ($urandom_range(0, 9) == 0) begin
          d = longint'($urandom);
          s = longint'($urandom);
        end else begin
          d = longint'($urandom_range(0, 16));
          s = longint'($urandom_range(0, 12));
        end
        applyStimulus(ch, d, s, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 7) == 0));
      end else if (r < 150) begin
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
